// File: rtl/adc_responder.sv
// SPI-style ADC slave model: decodes a start/SGL/ODD/MSBF command and shifts
// back a null bit plus a 10-bit sample, all logic clocked on the fast clk.
`timescale 1ns/1ps
module adc_responder (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       mosi,
  input  logic [9:0] sample0,
  input  logic [9:0] sample1,
  output logic       miso,
  output logic       miso_oe,
  output logic       channel,
  output logic       done,
  output logic       abort
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_NULL  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ncs_sync_q,  ncs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] vld_pipe_q,  vld_pipe_d;
  logic       armed_q,     armed_d;
  logic [2:0] state_q,     state_d;
  logic [3:0] cnt_q,       cnt_d;
  logic [9:0] shift_q,     shift_d;
  logic       miso_q,      miso_d;
  logic       miso_oe_q,   miso_oe_d;
  logic       channel_q,   channel_d;
  logic       done_q,      done_d;
  logic       abort_q,     abort_d;

  logic sync_ok, ncs_low, sclk_rise, sclk_fall, ncs_rise, ncs_fall, mosi_s;

  // Stage [1] is the synchronized level, stage [2] the previous one.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    ncs_sync_d  = {ncs_sync_q[1:0], ncs};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    vld_pipe_d  = {vld_pipe_q[1:0], 1'b1};
  end

  // Edges are only trusted once the synchronizers hold real pin samples,
  // so reset values never masquerade as transitions.
  assign sync_ok   = vld_pipe_q[2];
  assign ncs_low   = ~ncs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sync_ok & ncs_low &  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = sync_ok & ncs_low & ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign ncs_rise  = sync_ok &  ncs_sync_q[1] & ~ncs_sync_q[2];
  assign ncs_fall  = sync_ok & ~ncs_sync_q[1] &  ncs_sync_q[2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    channel_d = channel_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    // A frame is only accepted after ncs has been seen high since reset.
    armed_d   = armed_q | (sync_ok & ncs_sync_q[2]);

    if (state_q == S_IDLE) begin
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      if (armed_q && ncs_fall) begin
        state_d   = S_WAIT;
        miso_oe_d = 1'b1;
      end
    end else if (ncs_rise) begin
      // ncs wins over any sclk edge seen in the same cycle.
      state_d   = S_IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      abort_d   = (state_q != S_HOLD);
    end else begin
      case (state_q)
        S_WAIT: begin
          if (sclk_rise && mosi_s) begin
            state_d = S_CMD;
            cnt_d   = 4'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            if (cnt_q == 4'd1)
              channel_d = mosi_s;
            if (cnt_q == 4'd2) begin
              shift_d = channel_q ? sample1 : sample0;
              state_d = S_NULL;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_NULL: begin
          if (sclk_fall) begin
            miso_d  = 1'b0;
            state_d = S_DATA;
            cnt_d   = 4'd0;
          end
        end
        S_DATA: begin
          if (sclk_fall && cnt_q != 4'd10) begin
            miso_d  = shift_q[9];
            shift_d = {shift_q[8:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end else if (sclk_rise && cnt_q == 4'd10) begin
            done_d  = 1'b1;
            miso_d  = 1'b0;
            state_d = S_HOLD;
          end
        end
        S_HOLD: miso_d = 1'b0;
        default: begin
          state_d   = S_IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      ncs_sync_q  <= 3'b111;
      mosi_sync_q <= 2'b00;
      vld_pipe_q  <= 3'b000;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 10'd0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      channel_q   <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_pipe_q  <= vld_pipe_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      channel_q   <= channel_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign channel = channel_q;
  assign done    = done_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: a behavioural SPI-master model predicts the
// miso stream per rising edge, plus a per-cycle checker for pulses and idle state.
`timescale 1ns/1ps
module tb_adc_responder;
  logic       clk = 1'b0;
  logic       reset, sclk, ncs, mosi;
  logic [9:0] sample0, sample1;
  logic       miso, miso_oe, channel, done, abort;

  int   nvec = 0, nerr = 0;
  int   done_cnt = 0, abort_cnt = 0, ncs_hi = 0;
  logic exp_chan = 1'b0;
  logic [31:0] cap;

  always #12.5 clk = ~clk;

  adc_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ncs(ncs), .mosi(mosi),
    .sample0(sample0), .sample1(sample1), .miso(miso), .miso_oe(miso_oe),
    .channel(channel), .done(done), .abort(abort)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected miso seen by the master at rising edge r, given start bit index s.
  function automatic logic exp_miso(input int r, input int s, input logic [9:0] data);
    if (r >= s + 5 && r <= s + 14) return data[9 - (r - s - 5)];
    return 1'b0;
  endfunction

  // bits are sent MSB first; chg_at/rst_at < 0 disable those actions.
  task automatic run_frame(input logic [15:0] bits, input int nbits, input int nrise,
                           input logic [9:0] s0, input logic [9:0] s1,
                           input int chg_at, input logic [9:0] chg_val,
                           input int rst_at, output logic [31:0] capo);
    int   s;
    logic odd, rst_hit, full;
    logic [9:0] data;
    s = nbits;
    for (int i = 0; i < nbits; i++)
      if (s == nbits && bits[nbits - 1 - i]) s = i;
    odd  = (s + 2 < nbits) ? bits[nbits - 1 - (s + 2)] : 1'b0;
    data = odd ? s1 : s0;
    sample0 = s0; sample1 = s1;
    capo = 0; rst_hit = 1'b0;
    done_cnt = 0; abort_cnt = 0;
    ncs = 1'b0;
    #400;
    for (int r = 0; r < nrise; r++) begin
      mosi = (r < nbits) ? bits[nbits - 1 - r] : 1'b0;
      #200;
      chk($sformatf("miso_oe r%0d", r), miso_oe, 1);
      chk($sformatf("miso r%0d", r), miso, exp_miso(r, s, data));
      capo = {capo[30:0], miso};
      sclk = 1'b1;
      if (r == chg_at) sample0 = chg_val;
      if (r == rst_at) begin
        #100; reset = 1'b1;
        #1;
        chk("outputs in reset", {miso, miso_oe, channel, done, abort}, 0);
        #60; reset = 1'b0; exp_chan = 1'b0; rst_hit = 1'b1;
        #39; sclk = 1'b0;
        break;
      end
      #200; sclk = 1'b0;
    end
    mosi = 1'b0;
    #200; ncs = 1'b1;
    full = !rst_hit && (nrise >= s + 15);
    if (!rst_hit && nrise > s + 2) exp_chan = odd;
    #400;
    chk("done pulses", done_cnt, int'(full));
    chk("abort pulses", abort_cnt, int'(!full && !rst_hit));
    chk("channel", channel, exp_chan);
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; ncs = 1'b1; mosi = 1'b0;
    sample0 = '0; sample1 = '0;
    fork
      forever @(negedge clk) begin
        if (reset) begin
          ncs_hi = 0;
          chk("outputs in reset", {miso, miso_oe, channel, done, abort}, 0);
        end else begin
          chk("done and abort together", done & abort, 0);
          if (done)  done_cnt++;
          if (abort) abort_cnt++;
          if (ncs) ncs_hi++; else ncs_hi = 0;
          if (ncs_hi >= 5) begin
            chk("idle miso/miso_oe", {miso, miso_oe}, 0);
            chk("idle channel", channel, exp_chan);
          end
        end
      end
    join_none

    #105 reset = 1'b0;
    #400;
    chk("post-reset outputs", {miso, miso_oe, channel, done, abort}, 0);

    // sclk toggling with ncs high must be ignored
    done_cnt = 0; abort_cnt = 0;
    repeat (3) begin sclk = 1'b1; #200; sclk = 1'b0; #200; end
    chk("sclk while ncs high: oe", miso_oe, 0);
    chk("sclk while ncs high: pulses", done_cnt + abort_cnt, 0);

    run_frame(16'b1101, 4, 15, 10'h2AB, 10'h000, -1, 10'h0, -1, cap);
    chk("T1 stream", cap[10:0], 11'h2AB);
    chk("T1 channel", channel, 0);

    run_frame(16'b1111, 4, 15, 10'h000, 10'h3FF, -1, 10'h0, -1, cap);
    chk("T2 stream", cap[10:0], 11'h3FF);
    chk("T2 channel", channel, 1);

    run_frame(16'b001101, 6, 17, 10'h2AB, 10'h000, -1, 10'h0, -1, cap);
    chk("T3 stream", cap[16:0], 17'h002AB);
    chk("T3 channel", channel, 0);

    run_frame(16'b1111, 4, 7, 10'h000, 10'h3FF, -1, 10'h0, -1, cap);
    chk("T4 abort stream", cap[6:0], 7'b0000011);
    chk("T4 abort count", abort_cnt, 1);
    run_frame(16'b1101, 4, 15, 10'h2AB, 10'h000, -1, 10'h0, -1, cap);
    chk("T4 recovery stream", cap[10:0], 11'h2AB);

    run_frame(16'b1101, 4, 15, 10'h155, 10'h000, 4, 10'h0AA, -1, cap);
    chk("T5 late sample stream", cap[10:0], 11'h155);

    run_frame(16'b1101, 4, 15, 10'h2AB, 10'h000, -1, 10'h0, 8, cap);
    run_frame(16'b1101, 4, 15, 10'h2AB, 10'h000, -1, 10'h0, -1, cap);
    chk("T6 post-reset stream", cap[10:0], 11'h2AB);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
